// File: rtl/lampfpu_rnd_pack_if.sv
// Handshake/bus bundle between the div/sqrt datapath, the rounding/packing stage
// and the writeback consumer.
interface lampfpu_rnd_pack_if #(
  parameter int E_DW = 8,
  parameter int F_DW = 7
);
  logic              valid_i;
  logic              ready_o;
  logic              s_i;
  logic [E_DW-1:0]   e_i;
  logic [F_DW+4:0]   f_i;
  logic              isOverflow_i;
  logic              isUnderflow_i;
  logic              isToRound_i;
  logic              res_valid_o;
  logic              res_ready_i;
  logic [E_DW+F_DW:0] res_o;
  logic [2:0]        resFlags_o;
  logic [2:0]        flags_o;
  logic              flags_clr_i;

  modport slave (
    input  valid_i, s_i, e_i, f_i, isOverflow_i, isUnderflow_i, isToRound_i,
           res_ready_i, flags_clr_i,
    output ready_o, res_valid_o, res_o, resFlags_o, flags_o
  );

  modport master (
    output valid_i, s_i, e_i, f_i, isOverflow_i, isUnderflow_i, isToRound_i,
           res_ready_i, flags_clr_i,
    input  ready_o, res_valid_o, res_o, resFlags_o, flags_o
  );
endinterface

// File: rtl/lampfpu_rnd_pack.sv
// Round-to-nearest-even and bfloat16 packing stage with an output FIFO
// and sticky exception flags.
module lampfpu_rnd_pack #(
  parameter int LAMP_FLOAT_E_DW = 8,
  parameter int LAMP_FLOAT_F_DW = 7,
  parameter int OUT_DEPTH       = 2
) (
  input logic              clk,
  input logic              rst,
  lampfpu_rnd_pack_if.slave bus
);
  localparam int FW    = LAMP_FLOAT_F_DW + 5;
  localparam int EXT_W = LAMP_FLOAT_E_DW + 2;
  localparam int RW    = LAMP_FLOAT_E_DW + LAMP_FLOAT_F_DW + 1;
  localparam int PW    = $clog2(OUT_DEPTH);
  localparam int CW    = PW + 1;
  localparam logic [EXT_W-1:0] EMAX = {2'b00, {LAMP_FLOAT_E_DW{1'b1}}};

  logic [FW-1:0]              w_fn;
  logic [EXT_W-1:0]           w_eExt;
  logic [EXT_W-1:0]           w_eFin;
  logic                       w_loss;
  logic                       w_lsb;
  logic                       w_g;
  logic                       w_st;
  logic                       w_roundUp;
  logic                       w_nx;
  logic                       w_uf;
  logic                       w_ofl;
  logic [LAMP_FLOAT_F_DW+1:0] w_mant;
  logic [LAMP_FLOAT_F_DW-1:0] w_frac;
  logic [RW-1:0]              w_res;
  logic [2:0]                 w_flags;

  always_comb begin
    w_fn   = bus.f_i;
    w_eExt = {2'b00, bus.e_i};
    w_loss = 1'b0;
    // Overflow bit set: renormalise so the hidden bit sits at [FW-2]
    if (bus.f_i[FW-1]) begin
      w_fn   = {1'b0, bus.f_i[FW-1:2], bus.f_i[1] | bus.f_i[0]};
      w_eExt = {2'b00, bus.e_i} + EXT_W'(1);
      w_loss = bus.f_i[0];
    end
    w_lsb     = w_fn[3];
    w_g       = w_fn[2];
    w_st      = w_fn[1] | w_fn[0];
    w_roundUp = w_g & (w_st | w_lsb);
    w_mant    = {1'b0, w_fn[FW-2:3]} + {{(LAMP_FLOAT_F_DW+1){1'b0}}, w_roundUp};
    w_frac    = w_mant[LAMP_FLOAT_F_DW-1:0];
    w_eFin    = w_eExt;
    if (w_mant[LAMP_FLOAT_F_DW+1]) begin
      w_frac = '0;
      w_eFin = w_eExt + EXT_W'(1);
    end else if ((w_eExt == '0) && w_mant[LAMP_FLOAT_F_DW]) begin
      w_eFin = EXT_W'(1);
    end
    w_nx  = w_g | w_st | w_loss;
    w_uf  = (bus.isUnderflow_i | (w_eFin == '0)) & w_nx;
    w_ofl = (w_eFin >= EMAX) | bus.isOverflow_i;

    if (!bus.isToRound_i) begin
      w_res   = {bus.s_i, bus.e_i, bus.f_i[LAMP_FLOAT_F_DW+2:3]};
      w_flags = 3'b000;
    end else if (w_ofl) begin
      w_res   = {bus.s_i, {LAMP_FLOAT_E_DW{1'b1}}, {LAMP_FLOAT_F_DW{1'b0}}};
      w_flags = 3'b101;
    end else begin
      w_res   = {bus.s_i, w_eFin[LAMP_FLOAT_E_DW-1:0], w_frac};
      w_flags = {1'b0, w_uf, w_nx};
    end
  end

  logic [RW-1:0] r_memRes   [OUT_DEPTH];
  logic [2:0]    r_memFlags [OUT_DEPTH];
  logic [PW-1:0] r_wrPtr;
  logic [PW-1:0] r_rdPtr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_countNext;
  logic          r_ready;
  logic [2:0]    r_flags;
  logic          w_push;
  logic          w_pop;
  logic          w_headValid;

  assign w_headValid = (r_count != '0);
  assign w_push      = bus.valid_i & r_ready;
  assign w_pop       = w_headValid & bus.res_ready_i;

  always_comb begin
    w_countNext = r_count;
    if (w_push && !w_pop)      w_countNext = r_count + CW'(1);
    else if (!w_push && w_pop) w_countNext = r_count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_memRes[r_wrPtr]   <= w_res;
      r_memFlags[r_wrPtr] <= w_flags;
    end
  end

  // ready is registered from the next count so res_ready_i never reaches ready_o
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
      r_ready <= 1'b1;
      r_flags <= 3'b000;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + PW'(1);
      if (w_pop)  r_rdPtr <= r_rdPtr + PW'(1);
      r_count <= w_countNext;
      r_ready <= (w_countNext < CW'(OUT_DEPTH));
      if (w_pop)
        r_flags <= (bus.flags_clr_i ? 3'b000 : r_flags) | r_memFlags[r_rdPtr];
      else if (bus.flags_clr_i)
        r_flags <= 3'b000;
    end
  end

  assign bus.ready_o     = r_ready;
  assign bus.res_valid_o = w_headValid;
  assign bus.res_o       = w_headValid ? r_memRes[r_rdPtr] : '0;
  assign bus.resFlags_o  = w_headValid ? r_memFlags[r_rdPtr] : 3'b000;
  assign bus.flags_o     = r_flags;
endmodule

// File: tb/tb_lampfpu_rnd_pack.sv
// Directed-vector bench for the bfloat16 round/pack stage: rounding cases,
// FIFO backpressure, sticky flags and reset.
module tb_lampfpu_rnd_pack;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  lampfpu_rnd_pack_if bus ();

  lampfpu_rnd_pack dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic setBundle(input logic s, input logic [7:0] e, input logic [11:0] f,
                           input logic ovf, input logic unf, input logic rnd);
    bus.s_i           = s;
    bus.e_i           = e;
    bus.f_i           = f;
    bus.isOverflow_i  = ovf;
    bus.isUnderflow_i = unf;
    bus.isToRound_i   = rnd;
  endtask

  // One-cycle push of a bundle with the consumer stalled
  task automatic applyStimulus(input logic s, input logic [7:0] e, input logic [11:0] f,
                               input logic ovf, input logic unf, input logic rnd);
    setBundle(s, e, f, ovf, unf, rnd);
    bus.valid_i = 1'b1;
    step();
    bus.valid_i = 1'b0;
  endtask

  task automatic popOne();
    bus.res_ready_i = 1'b1;
    step();
    bus.res_ready_i = 1'b0;
  endtask

  task automatic clearFlags();
    bus.flags_clr_i = 1'b1;
    step();
    bus.flags_clr_i = 1'b0;
  endtask

  task automatic checkRes(input string tag, input logic [15:0] res, input logic [2:0] fl);
    checkOutput({tag, "_valid"}, {15'd0, bus.res_valid_o}, 16'd1);
    checkOutput({tag, "_res"}, bus.res_o, res);
    checkOutput({tag, "_flags"}, {13'd0, bus.resFlags_o}, {13'd0, fl});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.valid_i = 1'b0;
    bus.res_ready_i = 1'b0;
    bus.flags_clr_i = 1'b0;
    setBundle(1'b0, 8'h00, 12'h000, 1'b0, 1'b0, 1'b0);
    step();
    step();
    rst = 1'b0;
    $display("[TB] reset released");
    checkOutput("rst_valid", {15'd0, bus.res_valid_o}, 16'd0);
    checkOutput("rst_res", bus.res_o, 16'h0000);
    checkOutput("rst_resFlags", {13'd0, bus.resFlags_o}, 16'd0);
    checkOutput("rst_flags", {13'd0, bus.flags_o}, 16'd0);
    checkOutput("rst_ready", {15'd0, bus.ready_o}, 16'd1);

    applyStimulus(1'b0, 8'h7F, 12'h404, 1'b0, 1'b0, 1'b1);
    checkRes("tieEven", 16'h3F80, 3'b001);
    popOne();
    checkOutput("tieEven_drained", {15'd0, bus.res_valid_o}, 16'd0);
    checkOutput("tieEven_sticky", {13'd0, bus.flags_o}, 16'd1);
    clearFlags();
    checkOutput("clr_alone", {13'd0, bus.flags_o}, 16'd0);

    applyStimulus(1'b0, 8'h7F, 12'h40C, 1'b0, 1'b0, 1'b1);
    checkRes("tieOdd", 16'h3F82, 3'b001);
    popOne();
    applyStimulus(1'b0, 8'h7E, 12'h7FC, 1'b0, 1'b0, 1'b1);
    checkRes("mantCarry", 16'h3F80, 3'b001);
    popOne();
    clearFlags();

    applyStimulus(1'b0, 8'hFE, 12'h7FC, 1'b0, 1'b0, 1'b1);
    checkRes("ovfRound", 16'h7F80, 3'b101);
    popOne();
    checkOutput("ovf_sticky", {13'd0, bus.flags_o}, 16'h0005);

    applyStimulus(1'b1, 8'h40, 12'h000, 1'b1, 1'b0, 1'b1);
    checkRes("ovfUpstream", 16'hFF80, 3'b101);
    // Clear coincides with popping: flags become only the popped entry's flags
    applyStimulus(1'b0, 8'h7F, 12'h404, 1'b0, 1'b0, 1'b1);
    bus.flags_clr_i = 1'b1;
    bus.res_ready_i = 1'b1;
    step();
    bus.flags_clr_i = 1'b0;
    bus.res_ready_i = 1'b0;
    checkOutput("clrWithPop", {13'd0, bus.flags_o}, 16'h0005);
    popOne();
    checkOutput("clrWithPop_nx", {13'd0, bus.flags_o}, 16'h0005);
    clearFlags();
    applyStimulus(1'b0, 8'h7F, 12'h404, 1'b0, 1'b0, 1'b1);
    bus.flags_clr_i = 1'b1;
    bus.res_ready_i = 1'b1;
    step();
    bus.flags_clr_i = 1'b0;
    bus.res_ready_i = 1'b0;
    checkOutput("clrPop_base", {13'd0, bus.flags_o}, 16'h0001);
    applyStimulus(1'b0, 8'hFE, 12'h7FC, 1'b0, 1'b0, 1'b1);
    popOne();
    applyStimulus(1'b0, 8'h7F, 12'h404, 1'b0, 1'b0, 1'b1);
    checkOutput("preClr_flags", {13'd0, bus.flags_o}, 16'h0005);
    bus.flags_clr_i = 1'b1;
    bus.res_ready_i = 1'b1;
    step();
    bus.flags_clr_i = 1'b0;
    bus.res_ready_i = 1'b0;
    checkOutput("clrPop_nxOnly", {13'd0, bus.flags_o}, 16'h0001);
    clearFlags();

    applyStimulus(1'b0, 8'hFF, 12'h200, 1'b0, 1'b0, 1'b0);
    checkRes("passNaN", 16'h7FC0, 3'b000);
    popOne();
    checkOutput("passNaN_sticky", {13'd0, bus.flags_o}, 16'd0);
    applyStimulus(1'b0, 8'h7F, 12'h800, 1'b0, 1'b0, 1'b1);
    checkRes("preNorm", 16'h4000, 3'b000);
    popOne();
    applyStimulus(1'b0, 8'h00, 12'h3FC, 1'b0, 1'b0, 1'b1);
    checkRes("denormToNorm", 16'h0080, 3'b001);
    popOne();
    applyStimulus(1'b1, 8'h00, 12'h00C, 1'b0, 1'b1, 1'b1);
    checkRes("denormUF", 16'h8002, 3'b011);
    popOne();
    clearFlags();

    $display("[TB] backpressure sequence");
    setBundle(1'b0, 8'h7F, 12'h404, 1'b0, 1'b0, 1'b1);
    bus.valid_i = 1'b1;
    step();
    checkOutput("bp_ready1", {15'd0, bus.ready_o}, 16'd1);
    setBundle(1'b0, 8'h7F, 12'h40C, 1'b0, 1'b0, 1'b1);
    step();
    checkOutput("bp_readyLow", {15'd0, bus.ready_o}, 16'd0);
    checkOutput("bp_head", bus.res_o, 16'h3F80);
    setBundle(1'b0, 8'h7F, 12'h800, 1'b0, 1'b0, 1'b1);
    step();
    checkOutput("bp_held", {15'd0, bus.ready_o}, 16'd0);
    checkOutput("bp_headStill", bus.res_o, 16'h3F80);
    bus.res_ready_i = 1'b1;
    step();
    checkOutput("bp_pop1", bus.res_o, 16'h3F82);
    checkOutput("bp_readyBack", {15'd0, bus.ready_o}, 16'd1);
    step();
    bus.valid_i = 1'b0;
    checkOutput("bp_pop2", bus.res_o, 16'h4000);
    checkOutput("bp_pop2_flags", {13'd0, bus.resFlags_o}, 16'd0);
    step();
    bus.res_ready_i = 1'b0;
    checkOutput("bp_empty", {15'd0, bus.res_valid_o}, 16'd0);
    checkOutput("bp_readyEnd", {15'd0, bus.ready_o}, 16'd1);
    checkOutput("bp_sticky", {13'd0, bus.flags_o}, 16'h0001);

    applyStimulus(1'b0, 8'h7F, 12'h404, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h7F, 12'h40C, 1'b0, 1'b0, 1'b1);
    checkOutput("full_ready", {15'd0, bus.ready_o}, 16'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("rstFull_valid", {15'd0, bus.res_valid_o}, 16'd0);
    checkOutput("rstFull_flags", {13'd0, bus.flags_o}, 16'd0);
    checkOutput("rstFull_ready", {15'd0, bus.ready_o}, 16'd1);
    checkOutput("rstFull_res", bus.res_o, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
